// File: rtl/bsg_link_pkg.sv
// Shared link constants and word types for the BSG off-chip link receive path.
package bsg_link_pkg;

  localparam int CH_W   = 8;
  localparam int BEATS  = 4;
  localparam int NUM_CH = 2;

  localparam int HALF_W = CH_W * BEATS;
  localparam int WORD_W = HALF_W * NUM_CH;

  typedef logic [63:0] word_t;
  typedef logic [31:0] half_t;

endpackage : bsg_link_pkg

// File: rtl/bsg_link_rx_fifo.sv
// Synchronous first-word-fall-through FIFO of link words.
// Occupancy is the single source of truth for full/empty; pointers wrap naturally.
module bsg_link_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [63:0]                data_i,
  input  logic                       pop_i,
  output logic [63:0]                data_o,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic                       full_o,
  output logic                       empty_o
);

  import bsg_link_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  word_t             mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              full, empty;
  logic              push_eff, pop_eff;

  assign full  = (occ_q == OCC_W'(DEPTH));
  assign empty = (occ_q == '0);

  // Qualify requests: never pop when empty, push when full only if a pop frees the slot.
  always_comb begin
    pop_eff  = pop_i & ~empty;
    push_eff = push_i & (~full | pop_eff);
  end

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_eff) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_eff) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_eff, pop_eff})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage array; contents need no reset since empty masks the output.
  always_ff @(posedge clk) begin
    if (!rst && push_eff) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Head word falls through; driven to zero while empty.
  always_comb begin
    data_o = '0;
    if (!empty) begin
      data_o = mem_q[rd_ptr_q];
    end
  end

  assign occupancy_o = occ_q;
  assign full_o      = full;
  assign empty_o     = empty;

endmodule : bsg_link_rx_fifo

// File: rtl/bsg_downstream_rx.sv
// Receive end of the BSG link: assembles byte beats on two channels into
// 64-bit words, buffers them, and returns one credit token per drained word.
module bsg_downstream_rx #(
  parameter int CH_W       = 8,
  parameter int BEATS      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          io_valid_in,
  input  logic [CH_W-1:0]               io_data_in_ch0,
  input  logic [CH_W-1:0]               io_data_in_ch1,
  output logic [63:0]                   core_data_out,
  output logic                          core_valid_out,
  input  logic                          core_ready_in,
  output logic                          io_token_out,
  output logic                          overflow_err,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  import bsg_link_pkg::*;

  localparam int CNT_W = $clog2(BEATS);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  half_t            asm_lo_q, asm_lo_d;
  half_t            asm_hi_q, asm_hi_d;
  logic             token_q, token_d;
  logic             overflow_q, overflow_d;

  half_t            asm_lo_with, asm_hi_with;
  word_t            word_in;
  logic             last_beat;
  logic             pop;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  word_t            fifo_data;
  logic [OCC_W-1:0] fifo_occ;

  // Merge the current beat's bytes into the partial word so the last beat can bypass in.
  always_comb begin
    asm_lo_with = asm_lo_q;
    asm_hi_with = asm_hi_q;
    for (int k = 0; k < BEATS; k++) begin
      if (io_valid_in && (beat_cnt_q == CNT_W'(k))) begin
        asm_lo_with[k*CH_W +: CH_W] = io_data_in_ch0;
        asm_hi_with[k*CH_W +: CH_W] = io_data_in_ch1;
      end
    end
  end

  // Beat counting, push/overflow decision and token generation.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    asm_lo_d   = asm_lo_with;
    asm_hi_d   = asm_hi_with;
    word_in    = {asm_hi_with, asm_lo_with};
    last_beat  = io_valid_in && (beat_cnt_q == CNT_W'(BEATS - 1));
    pop        = ~fifo_empty & core_ready_in;
    push       = last_beat & (~fifo_full | pop);
    overflow_d = overflow_q | (last_beat & fifo_full & ~pop);
    token_d    = pop;
    if (io_valid_in) begin
      if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  // Assembly, token and sticky error registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      asm_lo_q   <= '0;
      asm_hi_q   <= '0;
      token_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      asm_lo_q   <= asm_lo_d;
      asm_hi_q   <= asm_hi_d;
      token_q    <= token_d;
      overflow_q <= overflow_d;
    end
  end

  bsg_link_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .data_i      (word_in),
    .pop_i       (pop),
    .data_o      (fifo_data),
    .occupancy_o (fifo_occ),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign core_data_out  = fifo_data;
  assign core_valid_out = ~fifo_empty;
  assign io_token_out   = token_q;
  assign overflow_err   = overflow_q;
  assign occupancy      = fifo_occ;

endmodule : bsg_downstream_rx

// File: doc/bsg_downstream_rx.md
# bsg_downstream_rx

Receive end of the BSG off-chip link. It accepts byte-wide beats on two parallel I/O channels and reassembles each group of four beats into one 64-bit core word. Words are buffered in a small FIFO and delivered to the core through a valid/ready handshake. One credit token is returned to the upstream transmitter for every word the core drains, closing the credit loop that the upstream token/data path consumes.

## Interface
Parameters:
- CH_W, 8, bits per channel per beat
- BEATS, 4, beats per word; channel half = CH_W*BEATS = 32 bits
- FIFO_DEPTH, 8, word buffer depth, power of two; equals the upstream initial credit count

Ports:
- clk  in  1  link/core clock (single domain)
- rst  in  1  reset, synchronous, active-high
- io_valid_in  in  1  beat valid from link
- io_data_in_ch0  in  CH_W  channel 0 byte; carries word bits [31:0]
- io_data_in_ch1  in  CH_W  channel 1 byte; carries word bits [63:32]
- core_data_out  out  64  head-of-FIFO word
- core_valid_out  out  1  FIFO non-empty
- core_ready_in  in  1  core accepts word when high with core_valid_out
- io_token_out  out  1  one-cycle credit pulse, one per drained word
- overflow_err  out  1  sticky; word completed with FIFO full and no same-cycle pop
- occupancy  out  $clog2(FIFO_DEPTH)+1  words held

## Operation
- Beat counter beat_cnt (2 bits, 0..BEATS-1) advances on each io_valid_in; wraps 3->0.
- Beat k writes ch0 byte into asm_lo[8k+7:8k] and ch1 byte into asm_hi[8k+7:8k]; beat 0 is least significant.
- On beat k=BEATS-1, word {asm_hi_with_beat, asm_lo_with_beat} (current bytes bypassed in) is pushed.
- Push accepted when occupancy<FIFO_DEPTH, or when FIFO full and a pop occurs in the same cycle. Otherwise the word is dropped, overflow_err is set, and occupancy is unchanged.
- Pop = core_valid_out & core_ready_in. Simultaneous push and pop leaves occupancy unchanged and is legal at both empty (push only takes effect; no pop possible) and full.
- io_token_out is registered: high exactly one cycle after each pop cycle, low otherwise. Back-to-back pops give a continuous token high, one cycle per word.
- Idle cycles (io_valid_in=0) between beats of a word are allowed; partial assembly is held.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally; full/empty are derived from occupancy.
- overflow_err clears only on rst.

## Timing
- Reset values: beat_cnt=0, asm regs=0, FIFO empty, core_valid_out=0, core_data_out=0 (don't-care contents, but driven 0), io_token_out=0, overflow_err=0, occupancy=0.
- Reset mid-word discards the partial word; reset has priority over push and pop in the same cycle; no token is emitted for a pop in the reset cycle.
- Latency: last beat at cycle t -> core_valid_out=1 and word on core_data_out at t+1.
- Pop at cycle t -> io_token_out=1 at t+1; next FIFO entry is visible at t+1.
- Sustained throughput: one word per 4 beat cycles in, one word per cycle out.

## Structure
- Shared package bsg_link_pkg: CH_W, BEATS, NUM_CH=2, word_t (logic [63:0]), half_t (logic [31:0]).
- Sub-module bsg_link_rx_fifo: synchronous FIFO (push/pop/data/occupancy/full/empty) of word_t, depth FIFO_DEPTH, first-word-fall-through output. The top level holds beat assembly, overflow detection and token generation.

## Test plan
- Single word: 4 beats with ch0=11,22,33,44 and ch1=55,66,77,88 (hex), core_ready_in=0 -> at t+1 core_data_out=0x8877665544332211, core_valid_out=1, occupancy=1; raise ready -> pop, io_token_out pulses one cycle later, occupancy=0.
- Gapped beats: insert 3 idle cycles between each beat -> same word, no extra push.
- Fill: 8 words with ready=0 -> occupancy=8; 9th word -> dropped, overflow_err=1 (sticky), occupancy=8; drain 8 -> 8 token cycles, data in order, words 1..8 only.
- Full + simultaneous: FIFO full, last beat of 9th word in the same cycle as a pop -> accepted, overflow_err stays 0, occupancy stays 8.
- Reset mid-word: 2 beats, rst for 1 cycle, then 4 beats of word B -> only B delivered, beat alignment correct.
- Streaming: continuous beats with ready=1 -> 1 word per 4 cycles, 1 token per word, occupancy ≤1.
